vnu_cell: RTL

VNU_CELL -- requirements
Module: vnu_cell

---
 rtl/vnu_cell.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vnu_cell.sv
// LDPC variable-node cell: loads a channel LLR, decodes compressed check-node words,
// forms the posterior and emits extrinsic messages. Define VNU_SAT_EN for saturating lq_out.
module vnu_cell #(
  parameter int D_WID = 8,
  parameter int DV    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [D_WID-1:0] ch_llr,
  input  logic                    ch_valid,
  output logic                    ch_ready,
  input  logic [2*D_WID+9:0]      lr_in,
  input  logic [2:0]              lr_pos,
  input  logic                    lr_valid,
  output logic                    lr_ready,
  output logic signed [D_WID-1:0] lq_out,
  output logic                    lq_valid,
  input  logic                    lq_ready,
  output logic                    hard_bit,
  output logic                    hard_valid,
  input  logic                    flush
);

  localparam int PW = D_WID + 3;
  localparam int LW = D_WID + 1;
  localparam logic [2:0] LAST = 3'(DV - 1);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (D_WID - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_OUT = 3'd1,
    ACC      = 3'd2,
    SUM      = 3'd3,
    OUT      = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]              edge_cnt;
  logic signed [PW-1:0]    acc;
  logic signed [PW-1:0]    posterior;
  logic signed [D_WID-1:0] ch_q;
  logic                    hard_q;
  logic signed [LW-1:0]    lr_buf [8];

  logic                    lq_fire;
  logic                    lr_fire;
  logic                    at_last;

  logic [D_WID-1:0]        abs_least;
  logic [D_WID-1:0]        abs_less;
  logic [2:0]              least_loc;
  logic                    sign_xor;
  logic [5:0]              signs;
  logic [D_WID-1:0]        mag;
  logic                    sel_sign;
  logic signed [LW-1:0]    mag_ext;
  logic signed [LW-1:0]    lr_dec;
  logic signed [LW-1:0]    lr_cur;
  logic signed [PW-1:0]    sum_now;
  logic signed [PW-1:0]    diff;
  logic [D_WID-1:0]        lq_red;

  assign ch_ready   = (state == IDLE);
  assign lr_ready   = (state == ACC);
  assign lq_valid   = (state == INIT_OUT) || (state == OUT);
  assign hard_valid = (state == SUM);

  assign lq_fire = lq_valid && lq_ready;
  assign lr_fire = lr_valid && lr_ready;
  assign at_last = (edge_cnt == LAST);

  assign abs_least = lr_in[2*D_WID+9 -: D_WID];
  assign abs_less  = lr_in[D_WID+9 -: D_WID];
  assign least_loc = lr_in[9:7];
  assign sign_xor  = lr_in[6];
  assign signs     = lr_in[5:0];

  // Slots 6 and 7 have no own sign bit and never take the second-least magnitude.
  always_comb begin
    mag      = abs_least;
    sel_sign = 1'b0;
    case (lr_pos)
      3'd0:    sel_sign = signs[5];
      3'd1:    sel_sign = signs[4];
      3'd2:    sel_sign = signs[3];
      3'd3:    sel_sign = signs[2];
      3'd4:    sel_sign = signs[1];
      3'd5:    sel_sign = signs[0];
      default: sel_sign = 1'b0;
    endcase
    if ((lr_pos <= 3'd5) && (lr_pos == least_loc)) begin
      mag = abs_less;
    end
    mag_ext = {1'b0, mag};
    lr_dec  = (sel_sign ^ sign_xor) ? -mag_ext : mag_ext;
  end

  assign lr_cur  = lr_buf[edge_cnt];
  assign sum_now = {{(PW-D_WID){ch_q[D_WID-1]}}, ch_q} + acc;
  assign diff    = posterior - {{(PW-LW){lr_cur[LW-1]}}, lr_cur};

`ifdef VNU_SAT_EN
  always_comb begin
    lq_red = diff[D_WID-1:0];
    if (diff > SAT_MAX) begin
      lq_red = SAT_MAX[D_WID-1:0];
    end else if (diff < SAT_MIN) begin
      lq_red = SAT_MIN[D_WID-1:0];
    end
  end
`else
  assign lq_red = diff[D_WID-1:0];
`endif

  always_comb begin
    lq_out = '0;
    case (state)
      INIT_OUT: lq_out = ch_q;
      OUT:      lq_out = lq_red;
      default:  lq_out = '0;
    endcase
  end

  // The decision is visible combinationally during SUM and held afterwards.
  assign hard_bit = (state == SUM) ? sum_now[PW-1] : hard_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ch_valid) state_nxt = INIT_OUT;
      INIT_OUT: if (lq_fire && at_last) state_nxt = ACC;
      ACC:      if (lr_fire && at_last) state_nxt = SUM;
      SUM:      state_nxt = OUT;
      OUT:      if (lq_fire && at_last) state_nxt = ACC;
      default:  state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt  <= '0;
      acc       <= '0;
      posterior <= '0;
      ch_q      <= '0;
      hard_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        lr_buf[i] <= '0;
      end
    end else if (flush) begin
      edge_cnt <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ch_valid) begin
            ch_q     <= ch_llr;
            edge_cnt <= '0;
          end
        end
        INIT_OUT, OUT: begin
          if (lq_fire) begin
            edge_cnt <= at_last ? 3'd0 : edge_cnt + 3'd1;
          end
        end
        ACC: begin
          if (lr_fire) begin
            lr_buf[edge_cnt] <= lr_dec;
            acc              <= acc + {{(PW-LW){lr_dec[LW-1]}}, lr_dec};
            edge_cnt         <= at_last ? 3'd0 : edge_cnt + 3'd1;
          end
        end
        SUM: begin
          posterior <= sum_now;
          hard_q    <= sum_now[PW-1];
          acc       <= '0;
          edge_cnt  <= '0;
        end
        default: begin
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule
